pixel_readout_arbiter: RTL and testbench

PIXEL_READOUT_ARBITER -- requirements
Module: pixel_readout_arbiter

---
 rtl/pixel_readout_arbiter_pkg.sv | 23 ++
 rtl/readout_fifo_fwft.sv | 60 ++++++
 rtl/pixel_readout_arbiter.sv | 130 +++++++++++++
 tb/tb_pixel_readout_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_readout_arbiter_pkg.sv
// Shared definitions for the pixel readout arbiter: FSM states and the
// field layout of a readout word {addr, timestamp, ToT, FTOA}.
package pixel_readout_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        CLEAR,
        GUARD
    } arb_state_t;

    localparam int TOT_W    = 8;
    localparam int TS_W     = 9;
    localparam int FTOA_W   = 5;

    // Field offsets inside dout; the pixel address sits above DATA_W.
    localparam int FTOA_LSB = 0;
    localparam int TOT_LSB  = FTOA_LSB + FTOA_W;
    localparam int TS_LSB   = TOT_LSB + TOT_W;
    localparam int ADDR_LSB = TS_LSB + TS_W;
    localparam int DATA_W   = ADDR_LSB;

endpackage

// File: rtl/readout_fifo_fwft.sv
// First-word-fall-through FIFO: the head word is presented on dout whenever
// valid is high and leaves on valid & ready.
module readout_fifo_fwft #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk_40MHz,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop;
    logic             do_push;

    assign pop     = valid & ready;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk_40MHz) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign valid = (count != '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/pixel_readout_arbiter.sv
// Round-robin readout arbiter for a group of single pixels: grants one pixel
// at a time, stores its hit data in a FWFT FIFO and pulses its clear flag.
module pixel_readout_arbiter
    import pixel_readout_arbiter_pkg::*;
#(
    parameter int NPIX       = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CLR_CYCLES = 2
) (
    input  logic                                clk_40MHz,
    input  logic                                rst_n,
    input  logic [NPIX-1:0]                     hit_pixel,
    input  logic [NPIX-1:0]                     hit_over,
    input  logic                                shutter,
    input  logic [TOT_W*NPIX-1:0]               ToT_bus,
    input  logic [TS_W*NPIX-1:0]                ts_bus,
    input  logic [FTOA_W*NPIX-1:0]              ftoa_bus,
    input  logic                                dout_ready,
    output logic [NPIX-1:0]                     out_flag,
    output logic [DATA_W+$clog2(NPIX)-1:0]      dout,
    output logic                                dout_valid,
    output logic                                fifo_full
);

    localparam int ADDR_W = $clog2(NPIX);
    localparam int DOUT_W = DATA_W + ADDR_W;
    localparam int CNT_W  = $clog2(CLR_CYCLES + 1);

    arb_state_t        state;
    arb_state_t        next_state;
    logic [NPIX-1:0]   armed;
    logic [NPIX-1:0]   req;
    logic [ADDR_W-1:0] rr_ptr;
    logic [ADDR_W-1:0] grant_idx;
    logic [ADDR_W-1:0] sel_idx;
    logic [ADDR_W-1:0] cand;
    logic              sel_valid;
    logic [CNT_W-1:0]  clr_cnt;
    logic [NPIX-1:0]   out_flag_next;
    logic              fifo_push;
    logic [DOUT_W-1:0] fifo_din;

    // A pixel only becomes eligible again after a fresh discriminator hit.
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            armed <= '0;
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                if (hit_pixel[i]) begin
                    armed[i] <= 1'b1;
                end else if (state == GRANT && grant_idx == ADDR_W'(i)) begin
                    armed[i] <= 1'b0;
                end
            end
        end
    end

    assign req = armed & hit_over & {NPIX{~shutter}};

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int j = 0; j < NPIX; j++) begin
            cand = rr_ptr + ADDR_W'(j);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            out_flag  <= '0;
        end else begin
            state    <= next_state;
            out_flag <= out_flag_next;
            clr_cnt  <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            if (next_state == GRANT && state != GRANT) begin
                grant_idx <= sel_idx;
            end
            if (state == GRANT) begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

    // GUARD arbitrates like IDLE so back-to-back grants are CLR_CYCLES+2 apart.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, GUARD: next_state = (sel_valid && !fifo_full) ? GRANT : IDLE;
            GRANT:       next_state = CLEAR;
            CLEAR:       next_state = (clr_cnt == CNT_W'(CLR_CYCLES - 1)) ? GUARD : CLEAR;
            default:     next_state = IDLE;
        endcase
    end

    always_comb begin
        fifo_push     = (state == GRANT);
        fifo_din      = {grant_idx,
                         ts_bus[int'(grant_idx)*TS_W +: TS_W],
                         ToT_bus[int'(grant_idx)*TOT_W +: TOT_W],
                         ftoa_bus[int'(grant_idx)*FTOA_W +: FTOA_W]};
        out_flag_next = '0;
        if (next_state == CLEAR) begin
            out_flag_next = {{(NPIX-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    readout_fifo_fwft #(
        .WIDTH (DOUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_40MHz (clk_40MHz),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .din       (fifo_din),
        .ready     (dout_ready),
        .dout      (dout),
        .valid     (dout_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_pixel_readout_arbiter.sv
// Directed self-checking bench for pixel_readout_arbiter with the default
// parameters (4 pixels, 4-deep FIFO, 2 clear cycles).
module tb_pixel_readout_arbiter;

    localparam int NPIX   = 4;
    localparam int DOUT_W = 24;

    logic                clk_40MHz = 1'b0;
    logic                rst_n;
    logic [NPIX-1:0]     hit_pixel;
    logic [NPIX-1:0]     hit_over;
    logic                shutter;
    logic [8*NPIX-1:0]   ToT_bus;
    logic [9*NPIX-1:0]   ts_bus;
    logic [5*NPIX-1:0]   ftoa_bus;
    logic                dout_ready;
    logic [NPIX-1:0]     out_flag;
    logic [DOUT_W-1:0]   dout;
    logic                dout_valid;
    logic                fifo_full;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] rr_exp [16] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0,
                                4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0};

    always #5 clk_40MHz = ~clk_40MHz;

    pixel_readout_arbiter #(
        .NPIX       (4),
        .FIFO_DEPTH (4),
        .CLR_CYCLES (2)
    ) dut (
        .clk_40MHz  (clk_40MHz),
        .rst_n      (rst_n),
        .hit_pixel  (hit_pixel),
        .hit_over   (hit_over),
        .shutter    (shutter),
        .ToT_bus    (ToT_bus),
        .ts_bus     (ts_bus),
        .ftoa_bus   (ftoa_bus),
        .dout_ready (dout_ready),
        .out_flag   (out_flag),
        .dout       (dout),
        .dout_valid (dout_valid),
        .fifo_full  (fifo_full)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle(input int n);
        repeat (n) @(negedge clk_40MHz);
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] tot,
                                 input logic [8:0] ts, input logic [4:0] ftoa);
        ToT_bus[idx*8 +: 8]  = tot;
        ts_bus[idx*9 +: 9]   = ts;
        ftoa_bus[idx*5 +: 5] = ftoa;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        nextCycle(2);
        rst_n = 1'b1;
        nextCycle(1);
    endtask

    function automatic logic [23:0] expWord(input logic [1:0] addr, input logic [8:0] ts,
                                            input logic [7:0] tot, input logic [4:0] ftoa);
        return {addr, ts, tot, ftoa};
    endfunction

    initial begin
        rst_n      = 1'b0;
        hit_pixel  = '0;
        hit_over   = '0;
        shutter    = 1'b0;
        ToT_bus    = '0;
        ts_bus     = '0;
        ftoa_bus   = '0;
        dout_ready = 1'b0;
        nextCycle(2);
        checkOutput("reset_out_flag", 32'(out_flag), 32'h0);
        checkOutput("reset_dout_valid", 32'(dout_valid), 32'h0);
        checkOutput("reset_fifo_full", 32'(fifo_full), 32'h0);
        checkOutput("reset_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;
        nextCycle(1);

        // Single hit on pixel 2
        applyStimulus(2, 8'h5A, 9'h123, 5'h11);
        hit_pixel = 4'b0100;
        nextCycle(1);
        hit_pixel = 4'b0000;
        hit_over  = 4'b0100;
        nextCycle(1);
        checkOutput("single_grant_cycle", 32'(out_flag), 32'h0);
        nextCycle(1);
        checkOutput("single_flag_1", 32'(out_flag), 32'h4);
        checkOutput("single_valid", 32'(dout_valid), 32'h1);
        checkOutput("single_dout", 32'(dout), 32'hA46B51);
        nextCycle(1);
        checkOutput("single_flag_2", 32'(out_flag), 32'h4);
        nextCycle(1);
        checkOutput("single_guard", 32'(out_flag), 32'h0);
        nextCycle(6);
        checkOutput("single_no_regrant", 32'(out_flag), 32'h0);
        dout_ready = 1'b1;
        nextCycle(1);
        dout_ready = 1'b0;
        checkOutput("single_popped", 32'(dout_valid), 32'h0);
        hit_over = 4'b0000;
        applyReset();

        // Round-robin from pointer 0 with all four pixels requesting
        for (int i = 0; i < NPIX; i++) begin
            applyStimulus(i, 8'hA0 + 8'(i), 9'h0F0 + 9'(i), 5'h03 + 5'(i));
        end
        hit_pixel = 4'b1111;
        nextCycle(1);
        hit_pixel = 4'b0000;
        hit_over  = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            nextCycle(1);
            checkOutput($sformatf("rr_flag_%0d", k), 32'(out_flag), 32'(rr_exp[k]));
        end
        checkOutput("rr_fifo_full", 32'(fifo_full), 32'h1);
        dout_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            checkOutput($sformatf("rr_word_%0d", i), 32'(dout),
                        32'(expWord(2'(i), 9'h0F0 + 9'(i), 8'hA0 + 8'(i), 5'h03 + 5'(i))));
            nextCycle(1);
        end
        dout_ready = 1'b0;
        checkOutput("rr_drained", 32'(dout_valid), 32'h0);
        nextCycle(6);
        checkOutput("rearm_no_grant_flag", 32'(out_flag), 32'h0);
        checkOutput("rearm_no_grant_word", 32'(dout_valid), 32'h0);

        // Backpressure: four words fill the FIFO, the fifth request waits for a pop
        hit_pixel = 4'b1111;
        nextCycle(1);
        hit_pixel = 4'b0000;
        nextCycle(20);
        checkOutput("bp_full", 32'(fifo_full), 32'h1);
        hit_pixel = 4'b0001;
        nextCycle(1);
        hit_pixel = 4'b0000;
        nextCycle(6);
        checkOutput("bp_no_5th_grant", 32'(out_flag), 32'h0);
        checkOutput("bp_still_full", 32'(fifo_full), 32'h1);
        checkOutput("bp_head", 32'(dout), 32'(expWord(2'd0, 9'h0F0, 8'hA0, 5'h03)));
        dout_ready = 1'b1;
        nextCycle(1);
        dout_ready = 1'b0;
        checkOutput("bp_not_full", 32'(fifo_full), 32'h0);
        checkOutput("bp_head_next", 32'(dout), 32'(expWord(2'd1, 9'h0F1, 8'hA1, 5'h04)));
        nextCycle(1);
        checkOutput("bp_grant_cycle", 32'(out_flag), 32'h0);
        nextCycle(1);
        checkOutput("bp_5th_flag", 32'(out_flag), 32'h1);
        checkOutput("bp_full_again", 32'(fifo_full), 32'h1);
        hit_over = 4'b0000;
        applyReset();

        // Shutter masks requests; a shutter rise mid-CLEAR does not abort
        shutter  = 1'b1;
        hit_over = 4'b0010;
        applyStimulus(1, 8'h77, 9'h1AB, 5'h1F);
        hit_pixel = 4'b0010;
        nextCycle(1);
        hit_pixel = 4'b0000;
        nextCycle(6);
        checkOutput("sh_no_grant", 32'(out_flag), 32'h0);
        checkOutput("sh_no_word", 32'(dout_valid), 32'h0);
        shutter = 1'b0;
        nextCycle(1);
        checkOutput("sh_grant_cycle", 32'(out_flag), 32'h0);
        nextCycle(1);
        checkOutput("sh_flag_1", 32'(out_flag), 32'h2);
        checkOutput("sh_word", 32'(dout), 32'(expWord(2'd1, 9'h1AB, 8'h77, 5'h1F)));
        shutter = 1'b1;
        nextCycle(1);
        checkOutput("sh_flag_held", 32'(out_flag), 32'h2);
        nextCycle(1);
        checkOutput("sh_guard", 32'(out_flag), 32'h0);
        shutter  = 1'b0;
        hit_over = 4'b0000;
        applyReset();

        // Reset asserted mid-CLEAR
        hit_over = 4'b1000;
        applyStimulus(3, 8'h3C, 9'h055, 5'h0A);
        hit_pixel = 4'b1000;
        nextCycle(1);
        hit_pixel = 4'b0000;
        nextCycle(2);
        checkOutput("rst_pre_flag", 32'(out_flag), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_flag_async", 32'(out_flag), 32'h0);
        checkOutput("rst_valid_async", 32'(dout_valid), 32'h0);
        checkOutput("rst_dout_async", 32'(dout), 32'h0);
        nextCycle(1);
        rst_n = 1'b1;
        nextCycle(3);
        checkOutput("rst_disarmed", 32'(out_flag), 32'h0);
        hit_pixel = 4'b1000;
        nextCycle(1);
        hit_pixel = 4'b0000;
        nextCycle(1);
        checkOutput("rst_idle_grant_cycle", 32'(out_flag), 32'h0);
        nextCycle(1);
        checkOutput("rst_idle_flag", 32'(out_flag), 32'h8);
        checkOutput("rst_idle_word", 32'(dout), 32'(expWord(2'd3, 9'h055, 8'h3C, 5'h0A)));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
